// File: rtl/nbit_pipelined_adder.sv
// Segmented add/subtract: one SEG-bit ripple per stage, carry registered between stages.
// Latency: STAGES = N/SEG cycles from acceptance to out_valid; one operation per cycle.
// Backpressure: global enable, every stage holds while out_valid && !out_ready.
module nbit_pipelined_adder #(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int STAGES = N / SEG;
    localparam int L      = STAGES - 1;

    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      a_d   [STAGES];
    logic [N-1:0]      bx_q  [STAGES];
    logic [N-1:0]      bx_d  [STAGES];
    logic [N-1:0]      sum_q [STAGES];
    logic [N-1:0]      sum_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [N-1:0]      src_a   [STAGES];
    logic [N-1:0]      src_bx  [STAGES];
    logic [N-1:0]      src_sum [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [SEG:0]      seg_sum [STAGES];
    logic              adv;

    always_comb begin
        adv = !vld_q[L] || out_ready;

        // Stage 0 is fed from the ports; later stages from the previous stage register.
        src_a[0]   = a;
        src_bx[0]  = sub ? ~b : b;
        src_sum[0] = '0;
        src_c[0]   = sub | cin;
        src_v[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_bx[k]  = bx_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = c_q[k-1];
            src_v[k]   = vld_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, src_a[k][k*SEG +: SEG]}
                       + {1'b0, src_bx[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, src_c[k]};
            a_d[k]   = a_q[k];
            bx_d[k]  = bx_q[k];
            sum_d[k] = sum_q[k];
            c_d[k]   = c_q[k];
            vld_d[k] = vld_q[k];
            if (adv) begin
                a_d[k]                  = src_a[k];
                bx_d[k]                 = src_bx[k];
                sum_d[k]                = src_sum[k];
                sum_d[k][k*SEG +: SEG]  = seg_sum[k][SEG-1:0];
                c_d[k]                  = seg_sum[k][SEG];
                vld_d[k]                = src_v[k];
            end
        end

        ovf_d = ovf_q;
        if (adv) begin
            ovf_d = (src_a[L][N-1] == src_bx[L][N-1]) && (sum_d[L][N-1] != src_a[L][N-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
            end
            c_q   <= '0;
            vld_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                sum_q[k] <= sum_d[k];
            end
            c_q   <= c_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[L];
    assign s         = sum_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nbit_pipelined_adder.sv
// Bench for nbit_pipelined_adder: 32/8 instance against a delay-line scoreboard, plus a 1-stage 8-bit instance.
module tb_nbit_pipelined_adder;

    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, s;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        vld;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } ent_t;

    ent_t pipe[$];

    always #5 clk = ~clk;

    nbit_pipelined_adder #(.N(32), .SEG(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    nbit_pipelined_adder #(.N(8), .SEG(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cout(cout8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on whole numbers: unsigned range for carry, signed range for overflow.
    function automatic ent_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub);
        ent_t   e;
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            ur     = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ur     = ua + ub + longint'(mcin);
            sr     = sa + sb + longint'(mcin);
            e.cout = (ur >= 64'sh1_0000_0000);
        end
        e.s   = ur[31:0];
        e.ovf = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        e.vld = 1'b1;
        return e;
    endfunction

    task automatic flush_model();
        ent_t e;
        e.vld = 1'b0; e.s = '0; e.cout = 1'b0; e.ovf = 1'b0;
        pipe.delete();
        for (int i = 0; i < STAGES; i++) pipe.push_back(e);
    endtask

    // One clock cycle: drive, check the output stage against the model, clock, advance the model.
    task automatic cyc(input logic r, input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic isub, input logic ordy);
        ent_t f, e;
        logic adv;
        rst = r; in_valid = iv; a = ia; b = ib; cin = icin; sub = isub; out_ready = ordy;
        #2;
        f = pipe[0];
        chk("out_valid", {63'd0, out_valid}, {63'd0, f.vld});
        if (!r) chk("in_ready", {63'd0, in_ready}, {63'd0, (!f.vld || ordy)});
        if (f.vld) begin
            chk("s", {32'd0, s}, {32'd0, f.s});
            chk("cout", {63'd0, cout}, {63'd0, f.cout});
            chk("ovf", {63'd0, ovf}, {63'd0, f.ovf});
        end
        adv = !f.vld || ordy;
        @(posedge clk);
        if (r) begin
            flush_model();
        end else if (adv) begin
            void'(pipe.pop_front());
            e     = model(ia, ib, icin, isub);
            e.vld = iv;
            pipe.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic directed(input logic [31:0] da, input logic [31:0] db, input logic dcin,
                            input logic dsub, input logic [31:0] es, input logic ec, input logic eo);
        cyc(1'b0, 1'b1, da, db, dcin, dsub, 1'b1);
        idle(STAGES - 1);
        #1;
        chk("dir_valid", {63'd0, out_valid}, 64'd1);
        chk("dir_s", {32'd0, s}, {32'd0, es});
        chk("dir_cout", {63'd0, cout}, {63'd0, ec});
        chk("dir_ovf", {63'd0, ovf}, {63'd0, eo});
        idle(1);
    endtask

    task automatic directed8(input logic [7:0] da, input logic [7:0] db, input logic dcin,
                             input logic dsub, input logic [7:0] es, input logic ec, input logic eo);
        in_valid8 = 1'b1; a8 = da; b8 = db; cin8 = dcin; sub8 = dsub; out_ready8 = 1'b1;
        #2;
        chk("s8_in_ready", {63'd0, in_ready8}, 64'd1);
        chk("s8_pre_valid", {63'd0, out_valid8}, 64'd0);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        #2;
        chk("s8_valid", {63'd0, out_valid8}, 64'd1);
        chk("s8_s", {56'd0, s8}, {56'd0, es});
        chk("s8_cout", {63'd0, cout8}, {63'd0, ec});
        chk("s8_ovf", {63'd0, ovf8}, {63'd0, eo});
        @(posedge clk); #1;
        #2;
        chk("s8_drained", {63'd0, out_valid8}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] s_hold;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_s", {32'd0, s}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
        @(posedge clk); #1;

        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        directed(32'h1234_5678, 32'h0000_0001, 1'b1, 1'b1, 32'h1234_5677, 1'b1, 1'b0);

        // Back-to-back stream with one bubble after the third operation.
        for (int i = 0; i < 9; i++) begin
            if (i == 3) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            else cyc(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        end
        idle(STAGES + 1);

        // Fill the pipe, stall three cycles with operands offered, then drain.
        for (int i = 0; i < STAGES; i++)
            cyc(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        s_hold = s;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_s_hold", {32'd0, s}, {32'd0, s_hold});
        end
        idle(STAGES + 1);

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++)
            cyc(1'b0, 1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                1'($urandom), 1'($urandom_range(0, 3) != 0));
        idle(STAGES + 1);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("midrst_s", {32'd0, s}, 64'd0);
        idle(STAGES);
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        directed8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        directed8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nbit_pipelined_adder.md
# nbit_pipelined_adder

Parametrised, pipelined successor to the combinational N-bit ripple-carry adder. An N-bit add/subtract is split into N/SEG segments. Each segment resolves in its own pipeline stage, and the carry is registered between stages, so the critical path is one SEG-bit ripple regardless of N. A valid/ready handshake on both sides provides full throughput and back-pressure, so the block can sit directly in streaming datapaths.

## Interface
- N, default 32: operand and sum width; must be a multiple of SEG.
- SEG, default 8: segment width per stage; STAGES = N/SEG (STAGES = 1 is legal).
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- cin  input  1  carry-in; used only when sub = 0.
- sub  input  1  0: a + b + cin; 1: a - b (a + ~b + 1, cin ignored).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- s  output  N  sum/difference.
- cout  output  1  carry out of bit N-1; for sub = 1, 1 means no borrow.
- ovf  output  1  signed overflow.

## Operation
- Effective B: bx = sub ? ~b : b. Effective carry-in: c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds a[k*SEG +: SEG] + bx[k*SEG +: SEG] + carry from stage k-1. Stage 0 uses c0 as its carry.
- Stage k registers:
  - its sum segment;
  - its carry-out;
  - the not-yet-used upper segments of a and bx (input skew);
  - the lower sum segments already produced (output de-skew).
- The final stage registers:
  - the full s;
  - cout = carry out of the top segment;
  - ovf = (a[N-1] == bx[N-1]) && (s[N-1] != a[N-1]). This requires a[N-1] and bx[N-1] to be carried down the pipe.
- Each stage holds one valid bit. The valid bits shift along with the data.
- Arithmetic is modulo 2^N. No saturation.
- Flow control is a global enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - When adv = 1, every stage shifts one place, bubbles included.
  - When adv = 0, all stage registers hold.
  - Bubbles are not collapsed.
- An operand set is accepted when in_valid && in_ready.
- A result is consumed when out_valid && out_ready.
- Results are delivered in acceptance order. No reordering, no drops, no duplicates.

## Timing
- Reset (rst = 1 at a clock edge):
  - all stage valid bits clear;
  - out_valid = 0, s = 0, cout = 0, ovf = 0 from the next cycle;
  - in_ready = 1 whenever rst is low and out_valid is 0.
- Reset mid-operation flushes every in-flight operation; none of them is ever presented.
- Latency with no stall: operands accepted at edge T produce out_valid = 1 with their result during the cycle after edge T+STAGES-1, i.e. STAGES cycles.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0:
  - s, cout and ovf are held stable;
  - in_ready = 0;
  - no internal stage changes.
- Simultaneous consume and accept in the same cycle is legal and loses no bubble.
- in_valid = 0 while in_ready = 1 injects a bubble, which emerges STAGES cycles later as out_valid = 0.
- rst has priority over all handshake activity in the same cycle.

## Test plan
Use N = 32, SEG = 8 (4-cycle latency) unless stated otherwise.
- 0xFFFFFFFF + 0x00000001, cin = 0, sub = 0 -> after 4 cycles: s = 0x00000000, cout = 1, ovf = 0. Exercises the carry across all 3 stage boundaries.
- 0x7FFFFFFF + 0x00000000, cin = 1 -> s = 0x80000000, cout = 0, ovf = 1.
- sub = 1, 0x80000000 - 0x00000001 -> s = 0x7FFFFFFF, cout = 1, ovf = 1. Then sub = 1, 0x00000000 - 0x00000001 -> s = 0xFFFFFFFF, cout = 0, ovf = 0.
- Back-to-back stream with out_ready = 1:
  - 8 random operations on consecutive cycles, with a 1-cycle bubble after the 3rd;
  - results appear in order on consecutive cycles, the bubble appears as out_valid = 0, and every result matches the scoreboard.
- Pipeline full, then out_ready = 0 for 3 cycles -> in_ready = 0 and s held constant for all 3 cycles. out_ready = 1 -> the remaining results drain in order with none lost.
- Reset mid-stream: rst = 1 for 1 cycle with 3 operations in flight -> out_valid = 0 the next cycle and stays 0 until a new operation completes, 4 cycles after acceptance. Repeat the first scenario with N = 8, SEG = 8 (1 stage) -> 1-cycle latency.
